// File: rtl/rced_window_feeder.sv
// Window feeder and result collector for the Roberts-cross edge core.
// Buffers one raster line, forms each 2x2 window, restarts the core via
// core_rst_n, waits for core_done and hands the captured result downstream.
module rced_window_feeder #(
   parameter int unsigned W     = 4,
   parameter int unsigned IMG_W = 8,
   parameter int unsigned IMG_H = 8,
   parameter int unsigned TW    = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  pix_in,
   input  logic          pix_valid,
   output logic          pix_ready,
   output logic [W-1:0]  Bxs [3:0],
   output logic          core_rst_n,
   input  logic          core_done,
   input  logic [TW-1:0] core_Bz,
   output logic [TW-1:0] res,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          res_last
);

   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] ColMax = CW'(IMG_W - 1);
   localparam logic [RW-1:0] RowMax = RW'(IMG_H - 1);

   typedef enum logic [1:0] {
      StIdle,
      StClear,
      StRun,
      StOut
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [W-1:0]  prev_cur_q, prev_cur_d;
   logic [W-1:0]  prev_up_q, prev_up_d;
   logic [W-1:0]  bxs_q [3:0];
   logic [W-1:0]  bxs_d [3:0];
   logic [TW-1:0] res_q, res_d;
   logic          res_valid_q, res_valid_d;
   logic          res_last_q, res_last_d;

   logic [W-1:0]  lb_q [IMG_W];
   logic          lb_we;
   logic [W-1:0]  lb_up;
   logic          accept;

   // Pixels are only taken while idle; this is the whole backpressure scheme.
   assign pix_ready  = (state_q == StIdle);
   assign accept     = pix_valid & pix_ready;
   assign lb_up      = lb_q[col_q];

   assign core_rst_n = rst_n & (state_q != StClear);
   assign Bxs        = bxs_q;
   assign res        = res_q;
   assign res_valid  = res_valid_q;
   assign res_last   = res_last_q;

   // Next-state: raster position, window capture and the core handshake FSM.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      prev_cur_d  = prev_cur_q;
      prev_up_d   = prev_up_q;
      bxs_d       = bxs_q;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      res_last_d  = res_last_q;
      lb_we       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               lb_we      = 1'b1;
               prev_cur_d = pix_in;
               // lb[col] read now becomes the upper-left pixel of the next window
               prev_up_d  = lb_up;
               if ((row_q != '0) && (col_q != '0)) begin
                  bxs_d[3]   = pix_in;
                  bxs_d[2]   = prev_cur_q;
                  bxs_d[1]   = lb_up;
                  bxs_d[0]   = prev_up_q;
                  res_last_d = (row_q == RowMax) && (col_q == ColMax);
                  state_d    = StClear;
               end
               if (col_q == ColMax) begin
                  col_d = '0;
                  row_d = (row_q == RowMax) ? '0 : row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         StClear: begin
            state_d = StRun;
         end
         StRun: begin
            if (core_done) begin
               res_d       = core_Bz;
               res_valid_d = 1'b1;
               state_d     = StOut;
            end
         end
         StOut: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         col_q       <= '0;
         row_q       <= '0;
         prev_cur_q  <= '0;
         prev_up_q   <= '0;
         bxs_q       <= '{default: '0};
         res_q       <= '0;
         res_valid_q <= 1'b0;
         res_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         prev_cur_q  <= prev_cur_d;
         prev_up_q   <= prev_up_d;
         bxs_q       <= bxs_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         res_last_q  <= res_last_d;
      end
   end

   // Line buffer; contents are don't-care after reset so it carries none.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         lb_q[col_q] <= pix_in;
      end
   end

endmodule

// File: tb/tb_rced_window_feeder.sv
// Randomized bench for rced_window_feeder with a behavioural core stub and a
// frame-level reference model of the expected windows and results.
module tb_rced_window_feeder;

   localparam int unsigned W     = 4;
   localparam int unsigned IMG_W = 4;
   localparam int unsigned IMG_H = 3;
   localparam int unsigned TW    = 5;
   localparam int unsigned NPix  = IMG_W * IMG_H;
   localparam int          Budget = 300;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  pix_in = '0;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   logic [W-1:0]  Bxs [3:0];
   logic          core_rst_n;
   logic          core_done;
   logic [TW-1:0] core_Bz;
   logic [TW-1:0] res;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic          res_last;

   rced_window_feeder #(
      .W     (W),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .TW    (TW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .Bxs        (Bxs),
      .core_rst_n (core_rst_n),
      .core_done  (core_done),
      .core_Bz    (core_Bz),
      .res        (res),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_last   (res_last)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pack_bxs();
      return {Bxs[3], Bxs[2], Bxs[1], Bxs[0]};
   endfunction

   // Core stub: counts core_delay cycles after release, then holds done high
   // with Bz = Bxs[3] + 1 until it is reset again.
   int            core_delay = 3;
   int            core_cnt = 0;
   logic          done_m = 1'b0;
   logic [TW-1:0] bz_m = '0;
   logic          spur = 1'b0;

   always @(posedge clk) begin
      if (!core_rst_n) begin
         core_cnt <= 0;
         done_m   <= 1'b0;
      end else if (!done_m) begin
         core_cnt <= core_cnt + 1;
         if (core_cnt + 1 >= core_delay) begin
            done_m <= 1'b1;
            bz_m   <= TW'(Bxs[3]) + TW'(1);
         end
      end
   end

   assign core_done = done_m | spur;
   assign core_Bz   = bz_m;

   // Reference model: the frame as a 2-D array, one expected window per
   // pixel with row>0 and col>0.
   typedef struct packed {
      logic [15:0]   win;
      logic [TW-1:0] r;
      logic          last;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] frame [IMG_H][IMG_W];
   int           m_row = 0;
   int           m_col = 0;

   function automatic void model_accept(input logic [W-1:0] v);
      exp_t e;
      frame[m_row][m_col] = v;
      if (m_row > 0 && m_col > 0) begin
         e.win  = {frame[m_row][m_col], frame[m_row][m_col-1],
                   frame[m_row-1][m_col], frame[m_row-1][m_col-1]};
         e.r    = TW'(v) + TW'(1);
         e.last = (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
         exp_q.push_back(e);
      end
      m_col++;
      if (m_col == IMG_W) begin
         m_col = 0;
         m_row = (m_row + 1) % IMG_H;
      end
   endfunction

   // Sink, spurious-done injector and per-cycle monitor, all at the falling edge.
   int   hold_cnt = 0;
   bit   stall_next = 1'b0;
   int   clr_cnt = 0;
   int   n_res = 0;
   bit   done_seen = 1'b0;
   exp_t e_front;

   always @(negedge clk) begin
      if (hold_cnt > 0) begin
         res_ready = 1'b0;
         if (res_valid) hold_cnt--;
      end else begin
         res_ready = ($urandom_range(0, 2) != 0);
      end
      spur = rst_n && (pix_ready || res_valid) && ($urandom_range(0, 3) == 0);
      if (rst_n && !core_rst_n) begin
         core_delay = stall_next ? 50 : int'($urandom_range(1, 5));
         stall_next = 1'b0;
         clr_cnt++;
      end
      if (!rst_n) begin
         done_seen = 1'b0;
      end else begin
         if (done_seen) check_val("res_valid_latency", res_valid, 1);
         done_seen = core_done && core_rst_n && !pix_ready && !res_valid;
         if (!pix_ready) begin
            if (exp_q.size() == 0) check_val("busy_without_window", 0, 1);
            else check_val("bxs_hold", pack_bxs(), exp_q[0].win);
         end
         if (res_valid) check_val("pix_ready_in_out", pix_ready, 0);
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               check_val("extra_result", res, 0);
               check_val("extra_result_seen", 1, 0);
            end else begin
               e_front = exp_q.pop_front();
               check_val("res", res, e_front.r);
               check_val("res_last", res_last, e_front.last);
               check_val("clear_pulses", clr_cnt, 1);
            end
            clr_cnt = 0;
            n_res++;
         end
      end
   end

   // Present one pixel until accepted; returns at the falling edge after acceptance.
   task automatic send_pix(input logic [W-1:0] v);
      int n = 0;
      pix_in    = v;
      pix_valid = 1'b1;
      #1;
      while (!pix_ready && n < Budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!pix_ready) begin
         check_val("pix_accept_timeout", 0, 1);
         pix_valid = 1'b0;
      end else begin
         model_accept(v);
         @(negedge clk);
         pix_valid = 1'b0;
      end
   endtask

   initial begin
      int n;
      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_pix_ready", pix_ready, 1);
      check_val("rst_res_valid", res_valid, 0);
      check_val("rst_res_last", res_last, 0);
      check_val("rst_res", res, 0);
      check_val("rst_bxs", pack_bxs(), 0);
      check_val("rst_core_rst_n", core_rst_n, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("core_rst_n_release", core_rst_n, 1);

      // Directed frame 0..11: first window stalls, first result held 10 cycles.
      hold_cnt   = 10;
      stall_next = 1'b1;
      for (int i = 0; i < int'(NPix); i++) begin
         send_pix(W'(i));
         if (i == 5) begin
            check_val("first_window_bxs", pack_bxs(), 32'h5410);
            check_val("clear_after_accept", core_rst_n, 0);
         end
      end

      // Two random frames back to back with random gaps.
      for (int i = 0; i < 2 * int'(NPix); i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send_pix(W'($urandom_range(0, 15)));
      end

      // Partial frame, reset during RUN of the third window.
      for (int i = 0; i < 8; i++) begin
         if (i == 7) stall_next = 1'b1;
         send_pix(W'($urandom_range(0, 15)));
      end
      repeat (3) @(negedge clk);
      #1;
      check_val("run_before_reset", {29'd0, pix_ready, res_valid, core_rst_n}, 3'b001);
      rst_n = 1'b0;
      #1;
      check_val("core_rst_n_in_reset", core_rst_n, 0);
      @(negedge clk);
      #1;
      check_val("midrst_pix_ready", pix_ready, 1);
      check_val("midrst_res_valid", res_valid, 0);
      check_val("midrst_res", res, 0);
      check_val("midrst_res_last", res_last, 0);
      check_val("midrst_bxs", pack_bxs(), 0);
      exp_q.delete();
      m_row   = 0;
      m_col   = 0;
      clr_cnt = 0;
      rst_n   = 1'b1;

      // Full frame after reset.
      for (int i = 0; i < int'(NPix); i++) begin
         repeat ($urandom_range(0, 1)) @(negedge clk);
         send_pix(W'($urandom_range(0, 15)));
      end

      // Drain, then idle with spurious done pulses still being injected.
      n = 0;
      while (exp_q.size() != 0 && n < Budget) begin
         @(negedge clk);
         n++;
      end
      repeat (12) @(negedge clk);
      #1;
      check_val("queue_empty", exp_q.size(), 0);
      check_val("results_total", n_res, 26);
      check_val("no_spurious_result", res_valid, 0);
      check_val("idle_at_end", pix_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
